// File: rtl/trace_feeder.sv
// rtl/trace_feeder.sv - buffers trace addresses from a loader and issues them to the cache core
// one at a time over the trace_ready/mem_addr/updated handshake.
module trace_feeder #(
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 16,
  parameter  int CNT_W  = 20,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  output logic              in_ready,
  output logic              trace_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              updated,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_count,
  output logic [LVL_W-1:0]  fifo_level
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state;
  logic [ADDR_W:0]    fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               last_seen;
  logic               cur_last;
  logic               full;
  logic               push;
  logic               pop;

  assign full     = (fifo_level == FULL_LVL);
  assign in_ready = !full && !last_seen;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (fifo_level != '0);

  // Storage carries no reset; occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_last, in_addr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_seen  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (in_last) begin
          last_seen <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // trace_ready is high only in ISSUE, so updated can never be seen in the pulse cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      trace_ready  <= 1'b0;
      mem_addr     <= '0;
      cur_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      trace_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {cur_last, mem_addr} <= fifo_mem[rd_ptr];
            trace_ready          <= 1'b1;
            busy                 <= 1'b1;
            state                <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (updated) begin
            if (issued_count != CNT_MAX) begin
              issued_count <= issued_count + CNT_W'(1);
            end
            busy <= 1'b0;
            if (cur_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
